mem_model: RTL and testbench

- Parametrised, ID-tagged, line-returning memory model that sits on the data-memory-engine memory port and replaces the ad-hoc single-cycle responder.
- Accepts word writes and line reads, keeping up to QUEUE_DEPTH reads outstanding.
- Returns each read line in order after a configurable latency, tagged with the ID issued at acceptance.
- Response is held until acknowledged.

---
 rtl/mem_model_pkg.sv | 40 ++++
 rtl/mem_model_queue.sv | 81 ++++++++
 rtl/mem_model.sv | 123 ++++++++++++
 tb/tb_mem_model.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and derived geometry for the mem_model memory-port responder.
// The default configuration here matches the mem_model parameter defaults.
package mem_model_pkg;

  localparam int PA_WIDTH_DEF    = 32;
  localparam int REG_WIDTH_DEF   = 32;
  localparam int LINE_WIDTH_DEF  = 128;
  localparam int MEM_LINES_DEF   = 64;
  localparam int QUEUE_DEPTH_DEF = 4;
  localparam int LATENCY_DEF     = 3;
  localparam int ID_WIDTH_DEF    = 4;

  // Countdown field is sized generously so LATENCY can be raised without retyping.
  localparam int CNT_WIDTH = 8;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int LINE_BYTES     = LINE_WIDTH_DEF / 8;
  localparam int WORDS_PER_LINE = LINE_WIDTH_DEF / REG_WIDTH_DEF;
  localparam int LINE_OFF_W     = $clog2(LINE_BYTES);
  localparam int WORD_OFF_LSB   = $clog2(REG_WIDTH_DEF / 8);
  localparam int WORD_SEL_W     = clog2_min1(WORDS_PER_LINE);
  localparam int LINE_IDX_W     = clog2_min1(MEM_LINES_DEF);

  typedef struct packed {
    logic                     write;
    logic [PA_WIDTH_DEF-1:0]  addr;
    logic [REG_WIDTH_DEF-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic [LINE_WIDTH_DEF-1:0] line;
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [CNT_WIDTH-1:0]      countdown;
    logic                      err;
  } mem_q_entry_t;

endpackage

// File: rtl/mem_model_queue.sv
// In-order FIFO of pending read responses; every slot's countdown ticks down
// each cycle so the head becomes presentable once its latency has elapsed.
module mem_model_queue
  import mem_model_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  mem_q_entry_t push_entry_i,
  input  logic         pop_i,
  output mem_q_entry_t head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  mem_q_entry_t     slot_q [DEPTH];
  mem_q_entry_t     slot_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign head_o  = slot_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].countdown != '0) begin
        slot_d[i].countdown = slot_q[i].countdown - 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/mem_model.sv
// ID-tagged, line-returning memory model: word writes, in-order line reads after LATENCY.
// Optional MEM_MODEL_OOR_ERR_EN flags reads above the store range and drops such writes.
module mem_model
  import mem_model_pkg::*;
#(
  parameter int PA_WIDTH    = PA_WIDTH_DEF,
  parameter int REG_WIDTH   = REG_WIDTH_DEF,
  parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int MEM_LINES   = MEM_LINES_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int LATENCY     = LATENCY_DEF,
  parameter int ID_WIDTH    = ID_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_enable,
  input  logic                  i_mem_write,
  input  logic [PA_WIDTH-1:0]   i_mem_addr,
  input  logic [REG_WIDTH-1:0]  i_mem_data,
  output logic                  o_mem_ready,
  output logic [ID_WIDTH-1:0]   o_mem_id_request,
  output logic                  o_resp_valid,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic [ID_WIDTH-1:0]   o_resp_id,
`ifdef MEM_MODEL_OOR_ERR_EN
  output logic                  o_resp_err,
`endif
  input  logic                  i_resp_ack
);

  localparam int WORDS       = LINE_WIDTH / REG_WIDTH;
  localparam int LINE_SHIFT  = $clog2(LINE_WIDTH / 8);
  localparam int WORD_SHIFT  = $clog2(REG_WIDTH / 8);
  localparam int IDX_W       = clog2_min1(MEM_LINES);
  localparam int SEL_W       = clog2_min1(WORDS);
  localparam int UPPER_SHIFT = LINE_SHIFT + $clog2(MEM_LINES);

  logic [LINE_WIDTH-1:0] store_q [MEM_LINES];
  logic [ID_WIDTH-1:0]   id_q, id_d;

  mem_req_t              req;
  mem_q_entry_t          push_entry;
  mem_q_entry_t          head;
  logic [IDX_W-1:0]      line_idx;
  logic [SEL_W-1:0]      word_sel;
  logic                  addr_oor;
  logic                  q_empty, q_full;
  logic                  accept, rd_accept, wr_accept;
  logic                  head_ready;

  assign req = '{write: i_mem_write, addr: i_mem_addr, data: i_mem_data};

  // Shift-and-mask keeps decode legal even when a field collapses to zero width.
  assign line_idx = IDX_W'((req.addr >> LINE_SHIFT) & PA_WIDTH'(MEM_LINES - 1));
  assign word_sel = SEL_W'((req.addr >> WORD_SHIFT) & PA_WIDTH'(WORDS - 1));

`ifdef MEM_MODEL_OOR_ERR_EN
  assign addr_oor = ((req.addr >> UPPER_SHIFT) != '0);
`else
  assign addr_oor = 1'b0;
`endif

  assign accept    = i_mem_enable && !q_full;
  assign rd_accept = accept && !req.write;
  assign wr_accept = accept && req.write && !addr_oor;

  always_comb begin
    push_entry           = '0;
    push_entry.line      = addr_oor ? '0 : store_q[line_idx];
    push_entry.id        = id_q;
    push_entry.countdown = CNT_WIDTH'(LATENCY - 1);
    push_entry.err       = addr_oor;
  end

  always_comb begin
    id_d = id_q;
    if (rd_accept) begin
      id_d = id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LINES; i++) begin
        store_q[i] <= '0;
      end
    end else if (wr_accept) begin
      store_q[line_idx][int'(word_sel)*REG_WIDTH +: REG_WIDTH] <= req.data;
    end
  end

  mem_model_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (rd_accept),
    .push_entry_i (push_entry),
    .pop_i        (head_ready && i_resp_ack),
    .head_o       (head),
    .empty_o      (q_empty),
    .full_o       (q_full)
  );

  assign head_ready       = !q_empty && (head.countdown == '0);
  assign o_mem_ready      = !q_full;
  assign o_mem_id_request = id_q;
  assign o_resp_valid     = head_ready;
  assign o_resp_data      = q_empty ? '0 : head.line;
  assign o_resp_id        = q_empty ? '0 : head.id;
`ifdef MEM_MODEL_OOR_ERR_EN
  assign o_resp_err       = head_ready && head.err;
`endif

endmodule

// File: tb/tb_mem_model.sv
// Directed bench for mem_model at default parameters (LATENCY=3, QUEUE_DEPTH=4).
module tb_mem_model;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_enable;
  logic         i_mem_write;
  logic [31:0]  i_mem_addr;
  logic [31:0]  i_mem_data;
  logic         o_mem_ready;
  logic [3:0]   o_mem_id_request;
  logic         o_resp_valid;
  logic [127:0] o_resp_data;
  logic [3:0]   o_resp_id;
  logic         i_resp_ack;
`ifdef MEM_MODEL_OOR_ERR_EN
  logic         o_resp_err;
`endif

  int checks   = 0;
  int failures = 0;

  mem_model dut (
    .clk              (clk),
    .rst              (rst),
    .i_mem_enable     (i_mem_enable),
    .i_mem_write      (i_mem_write),
    .i_mem_addr       (i_mem_addr),
    .i_mem_data       (i_mem_data),
    .o_mem_ready      (o_mem_ready),
    .o_mem_id_request (o_mem_id_request),
    .o_resp_valid     (o_resp_valid),
    .o_resp_data      (o_resp_data),
    .o_resp_id        (o_resp_id),
`ifdef MEM_MODEL_OOR_ERR_EN
    .o_resp_err       (o_resp_err),
`endif
    .i_resp_ack       (i_resp_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    #1;
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr);
    i_mem_enable = 1'b1; i_mem_write = 1'b0; i_mem_addr = addr;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    i_mem_enable = 1'b1; i_mem_write = 1'b1; i_mem_addr = addr; i_mem_data = data;
  endtask

  task automatic idle();
    i_mem_enable = 1'b0; i_mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_mem_enable = 1'b0; i_mem_write = 1'b0;
    i_mem_addr = '0; i_mem_data = '0; i_resp_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 128'(o_mem_ready), 128'd1);
    chk("rst_valid", 128'(o_resp_valid), 128'd0);
    chk("rst_data", o_resp_data, 128'd0);
    chk("rst_id", 128'(o_resp_id), 128'd0);
    chk("rst_idreq", 128'(o_mem_id_request), 128'd0);

    // write then read back with LATENCY=3
    wr(32'h8000, 32'hDEADBEEF);
    chk("wr_ready", 128'(o_mem_ready), 128'd1);
    tick();
    rd(32'h8000);
    chk("t1_idreq", 128'(o_mem_id_request), 128'd0);
    tick();
    idle();
    chk("t1_valid_c1", 128'(o_resp_valid), 128'd0);
    tick();
    chk("t1_valid_c2", 128'(o_resp_valid), 128'd0);
    tick();
    chk("t1_valid_c3", 128'(o_resp_valid), 128'd1);
    chk("t1_data", o_resp_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk("t1_id", 128'(o_resp_id), 128'd0);
    tick();
    chk("t1_hold_valid", 128'(o_resp_valid), 128'd1);
    chk("t1_hold_data", o_resp_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    i_resp_ack = 1'b1;
    tick();
    i_resp_ack = 1'b0;
    chk("t1_pop_valid", 128'(o_resp_valid), 128'd0);
    chk("t1_pop_data", o_resp_data, 128'd0);

    // fill the queue; line 0 still holds DEADBEEF via the 0x8000 alias
    rd(32'h00); chk("t2_idreq1", 128'(o_mem_id_request), 128'd1); tick();
    rd(32'h10); chk("t2_idreq2", 128'(o_mem_id_request), 128'd2); tick();
    rd(32'h20); tick();
    rd(32'h30); tick();
    rd(32'h40);
    chk("t2_full_ready", 128'(o_mem_ready), 128'd0);
    chk("t2_head_valid", 128'(o_resp_valid), 128'd1);
    chk("t2_head_id", 128'(o_resp_id), 128'd1);
    chk("t2_head_data", o_resp_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk("t2_idreq5", 128'(o_mem_id_request), 128'd5);
    tick();
    chk("t2_stall_ready", 128'(o_mem_ready), 128'd0);
    chk("t2_stall_id", 128'(o_resp_id), 128'd1);
    chk("t2_stall_idreq", 128'(o_mem_id_request), 128'd5);
    i_resp_ack = 1'b1;
    tick();
    chk("t2_pop_ready", 128'(o_mem_ready), 128'd1);
    chk("t2_pop_id", 128'(o_resp_id), 128'd2);
    chk("t2_pop_idreq", 128'(o_mem_id_request), 128'd5);
    tick();
    idle();
    chk("t2_pushpop_ready", 128'(o_mem_ready), 128'd1);
    chk("t2_pushpop_id", 128'(o_resp_id), 128'd3);
    chk("t2_pushpop_idreq", 128'(o_mem_id_request), 128'd6);
    tick();
    chk("t2_drain_id4", 128'(o_resp_id), 128'd4);
    tick();
    chk("t2_drain_valid5", 128'(o_resp_valid), 128'd1);
    chk("t2_drain_id5", 128'(o_resp_id), 128'd5);
    chk("t2_drain_data5", o_resp_data, 128'd0);
    tick();
    i_resp_ack = 1'b0;
    chk("t2_empty_valid", 128'(o_resp_valid), 128'd0);
    chk("t2_empty_id", 128'(o_resp_id), 128'd0);

    // snapshot: later write must not affect the queued read
    rd(32'h40);
    chk("t3_idreq", 128'(o_mem_id_request), 128'd6);
    tick();
    wr(32'h44, 32'hCAFEF00D);
    tick();
    idle();
    tick();
    chk("t3_snap_valid", 128'(o_resp_valid), 128'd1);
    chk("t3_snap_data", o_resp_data, 128'd0);
    chk("t3_snap_id", 128'(o_resp_id), 128'd6);
    i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;
    rd(32'h40); tick(); idle(); tick(); tick();
    chk("t3_new_data", o_resp_data, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0000);
    chk("t3_new_id", 128'(o_resp_id), 128'd7);
    i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;

    // reset with two reads outstanding
    rd(32'h00); tick();
    rd(32'h10); tick();
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_valid", 128'(o_resp_valid), 128'd0);
    chk("t5_ready", 128'(o_mem_ready), 128'd1);
    chk("t5_idreq", 128'(o_mem_id_request), 128'd0);
    chk("t5_data", o_resp_data, 128'd0);
    tick();
    chk("t5_no_stale", 128'(o_resp_valid), 128'd0);
    rd(32'h40); tick(); idle(); tick(); tick();
    chk("t5_read_valid", 128'(o_resp_valid), 128'd1);
    chk("t5_read_id", 128'(o_resp_id), 128'd0);
    chk("t5_read_data", o_resp_data, 128'd0);
    i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    // 17 reads with acks: IDs wrap 15 -> 0
    for (int i = 0; i < 17; i++) begin
      wr(32'(i * 16), 32'h100 + 32'(i)); tick();
      rd(32'(i * 16));
      chk($sformatf("t4_idreq_%0d", i), 128'(o_mem_id_request), 128'(i % 16));
      tick(); idle(); tick(); tick();
      chk($sformatf("t4_valid_%0d", i), 128'(o_resp_valid), 128'd1);
      chk($sformatf("t4_id_%0d", i), 128'(o_resp_id), 128'(i % 16));
      chk($sformatf("t4_data_%0d", i), o_resp_data, 128'h100 + 128'(i));
      i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;
    end

    // upper-address handling at 0x400; early ack while not valid is ignored
    wr(32'h400, 32'h12345678); tick();
    rd(32'h0);
    chk("t6_idreq", 128'(o_mem_id_request), 128'd1);
    tick(); idle(); i_resp_ack = 1'b1;
    chk("t6_early_valid", 128'(o_resp_valid), 128'd0);
    tick(); i_resp_ack = 1'b0; tick();
    chk("t6_valid", 128'(o_resp_valid), 128'd1);
    chk("t6_id", 128'(o_resp_id), 128'd1);
`ifdef MEM_MODEL_OOR_ERR_EN
    chk("t6_line0_kept", o_resp_data, 128'h100);
    chk("t6_line0_err", 128'(o_resp_err), 128'd0);
`else
    chk("t6_alias_data", o_resp_data, 128'h1234_5678);
`endif
    i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;
    rd(32'h400); tick(); idle(); tick(); tick();
    chk("t6_hi_valid", 128'(o_resp_valid), 128'd1);
    chk("t6_hi_id", 128'(o_resp_id), 128'd2);
`ifdef MEM_MODEL_OOR_ERR_EN
    chk("t6_hi_data", o_resp_data, 128'd0);
    chk("t6_hi_err", 128'(o_resp_err), 128'd1);
`else
    chk("t6_hi_data", o_resp_data, 128'h1234_5678);
`endif
    i_resp_ack = 1'b1; tick(); i_resp_ack = 1'b0;
    chk("t6_end_valid", 128'(o_resp_valid), 128'd0);
`ifdef MEM_MODEL_OOR_ERR_EN
    chk("t6_end_err", 128'(o_resp_err), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
